dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Shares the single data-memory port between the pipeline MEM stage and a debug/loader requester. The pipeline has priority. The debug side gets idle cycles opportunistically. A starvation counter forces a bounded debug burst, during which the whole pipeline is stalled. The block sits between the EX/MEM stage outputs and `datamemory`, and drives the pipeline-wide stall.

## Interface
- `DM_ADDRESS`, 9: data-memory address width
- `DATA_W`, 32: data width
- `STARVE_MAX`, 8: blocked debug cycles before a forced burst; must be ≥1
- `BURST_MAX`, 4: maximum beats per forced burst; must be ≥1

Ports:
- `clk` in 1: clock.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `cpu_rd`, `cpu_wr` in 1: MEM-stage read/write enables.
- `cpu_addr` in DM_ADDRESS: MEM-stage address.
- `cpu_wdata` in DATA_W: MEM-stage write data.
- `cpu_func3` in 3: MEM-stage access size.
- `cpu_rdata` out DATA_W: read data to MEM/WB.
- `cpu_stall` out 1: hold every pipeline register this cycle.
- `dbg_req` in 1: debug beat request.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in DM_ADDRESS: debug address.
- `dbg_wdata` in DATA_W: debug write data.
- `dbg_gnt` out 1: debug beat accepted this cycle.
- `dbg_rvalid` out 1: debug read data valid.
- `dbg_rdata` out DATA_W: debug read data.
- `mem_rd`, `mem_wr` out 1: memory enables.
- `mem_addr` out DM_ADDRESS: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_func3` out 3: memory access size.
- `mem_rdata` in DATA_W: memory read data, combinational in the same cycle as `mem_rd`.

## Operation
- `cpu_access` = `cpu_rd | cpu_wr`.
- **S_CPU** (reset state)
  - `cpu_stall` = 0.
  - `dbg_gnt` = `dbg_req & ~cpu_access`.
  - If `dbg_req & cpu_access`: CPU wins and `starve_cnt` increments.
  - When `starve_cnt` reaches STARVE_MAX: next state is S_DBG, `starve_cnt` clears, `beat_cnt` clears.
  - When `dbg_req` = 0 or the debug side is granted: `starve_cnt` clears.
- **S_DBG**
  - `cpu_stall` = 1 for every cycle in this state.
  - `dbg_gnt` = `dbg_req`.
  - `beat_cnt` increments per grant.
  - Exit to S_CPU after the cycle in which `dbg_req` = 0, or after the grant that makes `beat_cnt` equal BURST_MAX.
- **Port mux**
  - When `dbg_gnt`=1: memory sees `mem_rd` = ~`dbg_we`, `mem_wr` = `dbg_we`, `dbg_addr`, `dbg_wdata`, `mem_func3` = 3'b010 (word).
  - Otherwise memory sees the `cpu_*` fields, with `cpu_rd`/`cpu_wr` forced to 0 in S_DBG.
- `cpu_rdata` = `mem_rdata` (combinational).
- A granted debug read registers `mem_rdata` into `dbg_rdata` and pulses `dbg_rvalid` for 1 cycle. `dbg_rdata` holds its value until the next debug read.
- After S_DBG, `starve_cnt` restarts at 0. This guarantees the CPU at least STARVE_MAX uncontested cycles before the next forced burst.

## Timing
- **Reset values:** state = S_CPU, `starve_cnt` = 0, `beat_cnt` = 0, `dbg_rvalid` = 0, `dbg_rdata` = 0, `cpu_stall` = 0. `dbg_gnt` and `mem_*` follow inputs combinationally; with no requests they are 0.
- **Latency:**
  - Grant is in the request cycle.
  - Debug write completes at the grant edge.
  - Debug read data arrives 1 cycle after the grant.
  - CPU path adds 0 cycles.
- **Handshake:** the debug side holds `dbg_req`/`dbg_addr`/`dbg_wdata`/`dbg_we` stable until it sees `dbg_gnt`. One beat transfers per grant cycle.
- **Simultaneous events**
  - `cpu_access` and `dbg_req` in S_CPU below threshold: CPU wins.
  - In S_DBG, the CPU request is ignored and held by the stall; it replays when the stall releases.
- **Asynchronous reset** assertion mid-burst immediately returns state to S_CPU and drops `cpu_stall`. Any in-flight `dbg_rvalid` is cancelled.

## Structure
- Shared package `dmem_arb_pkg`:
  - state enum `arb_state_t` {S_CPU, S_DBG}
  - `FUNC3_WORD` = 3'b010
- Single module, no sub-module. `starve_cnt` is $clog2(STARVE_MAX+1) bits wide; `beat_cnt` is $clog2(BURST_MAX+1) bits wide.

## Test plan
- **Opportunistic read:** CPU idle, mem[0x010] = 0xDEADBEEF, `dbg_req` read 0x010 -> `dbg_gnt` = 1 in the same cycle, `mem_addr` = 0x010, next cycle `dbg_rvalid` = 1 with `dbg_rdata` = 0xDEADBEEF, `cpu_stall` never 1.
- **Contention:** `cpu_rd` every cycle, `dbg_req` write 0x55 to 0x020 held, STARVE_MAX = 8 -> `dbg_gnt` = 0 for 8 cycles; in cycle 9 `cpu_stall` = 1, `dbg_gnt` = 1, `mem_wr` = 1, `mem_func3` = 3'b010.
- **Burst cap:** as in Contention with `dbg_req` held, BURST_MAX = 4 -> exactly 4 grant cycles with stall, then ≥8 cycles with `cpu_stall` = 0 and `dbg_gnt` = 0.
- **Early release:** `dbg_req` drops after 2 beats in S_DBG -> S_CPU on the next cycle, `cpu_stall` = 0.
- **CPU priority:** in S_CPU with `starve_cnt` = 3, `cpu_wr` with `cpu_func3` = 3'b000 and `dbg_req` -> `mem_func3` = 3'b000, `mem_addr` = `cpu_addr`, `dbg_gnt` = 0, `starve_cnt` = 4.
- **Reset mid-burst:** `reset` low during the 2nd beat of S_DBG -> `cpu_stall`, `dbg_rvalid` and `dbg_rdata` go to 0 asynchronously; after release, state = S_CPU and `starve_cnt` = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Imported by dmem_port_arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DBG = 1'b1
  } arb_state_t;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the pipeline MEM stage and a debug requester.
// The pipeline has priority; a starvation counter forces a bounded, pipeline-stalling debug burst.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int BEAT_W   = $clog2(BURST_MAX + 1);

  arb_state_t            state_q, state_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  cpu_access;
  logic [STARVE_W-1:0]   starve_inc;
  logic [BEAT_W-1:0]     beat_inc;

  assign cpu_access = cpu_rd | cpu_wr;
  assign starve_inc = starve_q + STARVE_W'(1);
  assign beat_inc   = beat_q + BEAT_W'(1);

  // Arbitration state machine: next state, counters, stall and grant.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    beat_d    = beat_q;
    cpu_stall = 1'b0;
    dbg_gnt   = 1'b0;
    case (state_q)
      S_CPU: begin
        dbg_gnt = dbg_req & ~cpu_access;
        if (dbg_req && cpu_access) begin
          if (starve_inc == STARVE_W'(STARVE_MAX)) begin
            state_d  = S_DBG;
            starve_d = '0;
            beat_d   = '0;
          end else begin
            starve_d = starve_inc;
          end
        end else begin
          starve_d = '0;
        end
      end
      S_DBG: begin
        cpu_stall = 1'b1;
        dbg_gnt   = dbg_req;
        // Burst ends on the first idle debug cycle or on the capping beat.
        if (dbg_req) begin
          beat_d = beat_inc;
          if (beat_inc == BEAT_W'(BURST_MAX)) begin
            state_d = S_CPU;
          end else begin
            state_d = S_DBG;
          end
        end else begin
          state_d = S_CPU;
        end
      end
      default: begin
        state_d  = S_CPU;
        starve_d = '0;
        beat_d   = '0;
      end
    endcase
  end

  // Memory port mux; CPU enables are masked while the pipeline is stalled.
  always_comb begin
    if (dbg_gnt) begin
      mem_rd    = ~dbg_we;
      mem_wr    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_func3 = FUNC3_WORD;
    end else begin
      mem_rd    = cpu_rd & (state_q == S_CPU);
      mem_wr    = cpu_wr & (state_q == S_CPU);
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_func3 = cpu_func3;
    end
  end

  // Debug read return: capture on a granted read, hold otherwise.
  always_comb begin
    rvalid_d = dbg_gnt & ~dbg_we;
    if (rvalid_d) begin
      rdata_d = mem_rdata;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and read-return registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_CPU;
      starve_q <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;

endmodule
